// File: rtl/linha_envase_param.sv
// -----------------------------------------------------------------------------
// linha_envase_param
//   Single-lane wine bottling controller. A bottle travels through
//   fill -> cork/seal -> quality check -> capsule, and a good bottle is
//   counted into boxes at the end. The block holds the process FSM, the
//   conveyor motor decode, the cork stock and the bottle/box counters.
//   A fault timeout protects every conveyor move and the filling step.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   start             pulse, starts a cycle from IDLE
//   key_vedar         pulse, seal request (VEDAR only)
//   key_enter_cq      pulse, commit quality verdict (CQ only)
//   key_lacre         pulse, capsule applied, bottle counted (LACRE only)
//   add_rolha         pulse, adds ROLHA_LOTE corks (any state)
//   qualidade_ok      level, verdict sampled with key_enter_cq
//   sens_pos_ench     level, bottle at filling position
//   sens_pos_cq       level, bottle at QC position
//   sens_pos_lacre    level, bottle at capsule position
//   sens_cheia        level, bottle full
//   clear_fault       pulse, leaves FAULT
//   motor, valvula, atuador_vedacao, led_descarte   actuator outputs
//   dispensador       cork refill request (rolhas < ROLHA_MIN)
//   alarme_rolha      waiting to seal with an empty stock
//   fault             timeout fault active
//   estado            current state code
//   rolhas            cork stock
//   garrafas          bottles in the current box
//   caixas            completed boxes (saturating)
//   caixas_cheio      caixas == CAIXA_MAX
//
// State table
//   state       | meaning
//   IDLE     0  | waiting for start
//   MOVE_ENCH 1 | conveyor to filling position
//   ENCH     2  | valve open, filling
//   VEDAR    3  | waiting for seal request
//   SELANDO  4  | sealing actuator pulse (SELA_CYC cycles)
//   MOVE_CQ  5  | conveyor to QC position
//   CQ       6  | waiting for quality verdict
//   DESCARTE 7  | discard indication (DESC_CYC cycles)
//   MOVE_LACRE 8| conveyor to capsule position
//   LACRE    9  | waiting for capsule confirmation
//   FAULT   15  | timeout, actuators off until clear_fault
// -----------------------------------------------------------------------------
module linha_envase_param #(
  parameter int ROLHA_W      = 5,
  parameter int ROLHA_MAX    = 20,
  parameter int ROLHA_MIN    = 5,
  parameter int ROLHA_LOTE   = 5,
  parameter int GARRAFAS_CX  = 12,
  parameter int CAIXA_W      = 4,
  parameter int CAIXA_MAX    = 10,
  parameter int TIMEOUT      = 255,
  parameter int SELA_CYC     = 4,
  parameter int DESC_CYC     = 8,
  parameter int AUTO_RESTART = 0,
  localparam int GAR_W = (GARRAFAS_CX > 1) ? $clog2(GARRAFAS_CX) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               key_vedar,
  input  logic               key_enter_cq,
  input  logic               key_lacre,
  input  logic               add_rolha,
  input  logic               qualidade_ok,
  input  logic               sens_pos_ench,
  input  logic               sens_pos_cq,
  input  logic               sens_pos_lacre,
  input  logic               sens_cheia,
  input  logic               clear_fault,
  output logic               motor,
  output logic               valvula,
  output logic               atuador_vedacao,
  output logic               dispensador,
  output logic               led_descarte,
  output logic               alarme_rolha,
  output logic               fault,
  output logic [3:0]         estado,
  output logic [ROLHA_W-1:0] rolhas,
  output logic [GAR_W-1:0]   garrafas,
  output logic [CAIXA_W-1:0] caixas,
  output logic               caixas_cheio
);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_MOVE_ENCH  = 4'd1;
  localparam logic [3:0] S_ENCH       = 4'd2;
  localparam logic [3:0] S_VEDAR      = 4'd3;
  localparam logic [3:0] S_SELANDO    = 4'd4;
  localparam logic [3:0] S_MOVE_CQ    = 4'd5;
  localparam logic [3:0] S_CQ         = 4'd6;
  localparam logic [3:0] S_DESCARTE   = 4'd7;
  localparam logic [3:0] S_MOVE_LACRE = 4'd8;
  localparam logic [3:0] S_LACRE      = 4'd9;
  localparam logic [3:0] S_FAULT      = 4'd15;

  // One timer serves the timeout and both fixed-length pulses, so it is
  // sized for the longest of the three.
  localparam int T_MAX0 = (TIMEOUT > SELA_CYC) ? TIMEOUT : SELA_CYC;
  localparam int T_MAX  = (T_MAX0 > DESC_CYC) ? T_MAX0 : DESC_CYC;
  localparam int T_W    = $clog2(T_MAX + 1);

  // Wide enough to hold stock + one batch before saturation.
  localparam int R_SW   = $clog2(ROLHA_MAX + ROLHA_LOTE + 1);

  localparam logic [T_W-1:0]     TMR_TO    = T_W'(TIMEOUT - 1);
  localparam logic [T_W-1:0]     TMR_SELA  = T_W'(SELA_CYC - 1);
  localparam logic [T_W-1:0]     TMR_DESC  = T_W'(DESC_CYC - 1);
  localparam logic [R_SW-1:0]    R_LOTE    = R_SW'(ROLHA_LOTE);
  localparam logic [R_SW-1:0]    R_MAX     = R_SW'(ROLHA_MAX);
  localparam logic [ROLHA_W-1:0] R_MIN     = ROLHA_W'(ROLHA_MIN);
  localparam logic [GAR_W-1:0]   GAR_LAST  = GAR_W'(GARRAFAS_CX - 1);
  localparam logic [CAIXA_W-1:0] CX_MAX    = CAIXA_W'(CAIXA_MAX);

  logic [3:0]      state;
  logic [3:0]      state_nx;
  logic [T_W-1:0]  tmr;
  logic            tmr_to;
  logic            timed;
  logic            seal;
  logic            count;
  logic [R_SW-1:0] rol_sum;
  logic [R_SW-1:0] rol_nx;

  assign tmr_to = (tmr == TMR_TO);

  // States in which the timer runs; all others hold it at zero.
  always_comb begin
    timed = 1'b0;
    case (state)
      S_MOVE_ENCH, S_ENCH, S_SELANDO,
      S_MOVE_CQ, S_DESCARTE, S_MOVE_LACRE: timed = 1'b1;
      default:                             timed = 1'b0;
    endcase
  end

  // Next state. A sensor arriving on the terminal-count cycle still wins
  // over the fault.
  always_comb begin
    state_nx = state;
    seal     = 1'b0;
    count    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_MOVE_ENCH;
      end
      S_MOVE_ENCH: begin
        if (sens_pos_ench)  state_nx = S_ENCH;
        else if (tmr_to)    state_nx = S_FAULT;
      end
      S_ENCH: begin
        if (sens_cheia)     state_nx = S_VEDAR;
        else if (tmr_to)    state_nx = S_FAULT;
      end
      S_VEDAR: begin
        if (key_vedar && (rolhas != '0)) begin
          state_nx = S_SELANDO;
          seal     = 1'b1;
        end
      end
      S_SELANDO: begin
        if (tmr == TMR_SELA) state_nx = S_MOVE_CQ;
      end
      S_MOVE_CQ: begin
        if (sens_pos_cq)    state_nx = S_CQ;
        else if (tmr_to)    state_nx = S_FAULT;
      end
      S_CQ: begin
        if (key_enter_cq) state_nx = qualidade_ok ? S_MOVE_LACRE : S_DESCARTE;
      end
      S_DESCARTE: begin
        if (tmr == TMR_DESC) state_nx = S_IDLE;
      end
      S_MOVE_LACRE: begin
        if (sens_pos_lacre) state_nx = S_LACRE;
        else if (tmr_to)    state_nx = S_FAULT;
      end
      S_LACRE: begin
        if (key_lacre) begin
          count    = 1'b1;
          state_nx = (AUTO_RESTART != 0) ? S_MOVE_ENCH : S_IDLE;
        end
      end
      S_FAULT: begin
        if (clear_fault) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Timer restarts from zero on every state change, so each state entry
  // gets its full window.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmr <= '0;
    end else if ((state_nx != state) || !timed) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + 1'b1;
    end
  end

  // Cork stock: batch add and seal decrement are combined first and the
  // result is saturated, so add+seal on one cycle nets +ROLHA_LOTE-1.
  always_comb begin
    rol_sum = R_SW'(rolhas);
    if (add_rolha) rol_sum = rol_sum + R_LOTE;
    if (seal)      rol_sum = rol_sum - 1'b1;
    rol_nx = (rol_sum > R_MAX) ? R_MAX : rol_sum;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rolhas <= '0;
    end else begin
      rolhas <= rol_nx[ROLHA_W-1:0];
    end
  end

  // Bottle / box counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      garrafas <= '0;
      caixas   <= '0;
    end else if (count) begin
      if (garrafas == GAR_LAST) begin
        garrafas <= '0;
        if (caixas != CX_MAX) caixas <= caixas + 1'b1;
      end else begin
        garrafas <= garrafas + 1'b1;
      end
    end
  end

  // Moore output decode from the registered state.
  always_comb begin
    motor           = 1'b0;
    valvula         = 1'b0;
    atuador_vedacao = 1'b0;
    led_descarte    = 1'b0;
    alarme_rolha    = 1'b0;
    fault           = 1'b0;
    case (state)
      S_MOVE_ENCH, S_MOVE_CQ, S_MOVE_LACRE: motor = 1'b1;
      S_ENCH:     valvula         = 1'b1;
      S_VEDAR:    alarme_rolha    = (rolhas == '0);
      S_SELANDO:  atuador_vedacao = 1'b1;
      S_DESCARTE: led_descarte    = 1'b1;
      S_FAULT:    fault           = 1'b1;
      default: ;
    endcase
  end

  assign dispensador  = (rolhas < R_MIN);
  assign caixas_cheio = (caixas == CX_MAX);
  assign estado       = state;

endmodule

// File: tb/tb_linha_envase_param.sv
module tb_linha_envase_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, key_vedar = 1'b0, key_enter_cq = 1'b0, key_lacre = 1'b0;
  logic       add_rolha = 1'b0, qualidade_ok = 1'b0, clear_fault = 1'b0;
  logic       sens_pos_ench = 1'b0, sens_pos_cq = 1'b0, sens_pos_lacre = 1'b0, sens_cheia = 1'b0;
  logic       motor, valvula, atuador_vedacao, dispensador, led_descarte, alarme_rolha, fault;
  logic [3:0] estado;
  logic [4:0] rolhas;
  logic [3:0] garrafas;
  logic [3:0] caixas;
  logic       caixas_cheio;

  int n_cmp = 0;
  int n_err = 0;

  linha_envase_param dut (
    .clk(clk), .reset(reset), .start(start), .key_vedar(key_vedar),
    .key_enter_cq(key_enter_cq), .key_lacre(key_lacre), .add_rolha(add_rolha),
    .qualidade_ok(qualidade_ok), .sens_pos_ench(sens_pos_ench), .sens_pos_cq(sens_pos_cq),
    .sens_pos_lacre(sens_pos_lacre), .sens_cheia(sens_cheia), .clear_fault(clear_fault),
    .motor(motor), .valvula(valvula), .atuador_vedacao(atuador_vedacao),
    .dispensador(dispensador), .led_descarte(led_descarte), .alarme_rolha(alarme_rolha),
    .fault(fault), .estado(estado), .rolhas(rolhas), .garrafas(garrafas),
    .caixas(caixas), .caixas_cheio(caixas_cheio)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: one complete bottle from IDLE, with a cork batch first.
  task automatic drive_bottle(input bit ok);
    add_rolha = 1; tick(); add_rolha = 0;
    start = 1; tick(); start = 0;
    sens_pos_ench = 1; tick(); sens_pos_ench = 0;
    sens_cheia = 1; tick(); sens_cheia = 0;
    key_vedar = 1; tick(); key_vedar = 0;
    repeat (4) tick();
    sens_pos_cq = 1; tick(); sens_pos_cq = 0;
    qualidade_ok = ok; key_enter_cq = 1; tick(); key_enter_cq = 0;
    if (ok) begin
      sens_pos_lacre = 1; tick(); sens_pos_lacre = 0;
      key_lacre = 1; tick(); key_lacre = 0;
    end else begin
      repeat (8) tick();
    end
  endtask

  task automatic test_reset();
    reset = 1; tick(); tick(); reset = 0;
    n_cmp++; if (estado !== 4'd0) begin n_err++; $display("FAIL reset_estado got=%0d exp=0", estado); end
    n_cmp++; if ({motor, valvula, atuador_vedacao, led_descarte, alarme_rolha, fault} !== 6'b0) begin
      n_err++; $display("FAIL reset_outputs got=%b exp=000000", {motor, valvula, atuador_vedacao, led_descarte, alarme_rolha, fault}); end
    n_cmp++; if (dispensador !== 1'b1) begin n_err++; $display("FAIL reset_dispensador got=%b exp=1", dispensador); end
    n_cmp++; if ({rolhas, garrafas, caixas, caixas_cheio} !== 14'd0) begin
      n_err++; $display("FAIL reset_counters rolhas=%0d garrafas=%0d caixas=%0d cheio=%b exp=0", rolhas, garrafas, caixas, caixas_cheio); end
  endtask

  task automatic test_full_cycle();
    key_vedar = 1; tick(); key_vedar = 0;
    n_cmp++; if (estado !== 4'd0) begin n_err++; $display("FAIL t1_ignored_key got=%0d exp=0", estado); end
    add_rolha = 1; tick(); add_rolha = 0;
    n_cmp++; if (rolhas !== 5'd5 || dispensador !== 1'b0) begin n_err++; $display("FAIL t1_add rolhas=%0d disp=%b exp=5,0", rolhas, dispensador); end
    start = 1; tick(); start = 0;
    n_cmp++; if (estado !== 4'd1 || motor !== 1'b1) begin n_err++; $display("FAIL t1_move_ench estado=%0d motor=%b exp=1,1", estado, motor); end
    sens_pos_ench = 1; tick(); sens_pos_ench = 0;
    n_cmp++; if (estado !== 4'd2 || valvula !== 1'b1 || motor !== 1'b0) begin n_err++; $display("FAIL t1_ench estado=%0d valvula=%b exp=2,1", estado, valvula); end
    sens_cheia = 1; tick(); sens_cheia = 0;
    n_cmp++; if (estado !== 4'd3 || alarme_rolha !== 1'b0) begin n_err++; $display("FAIL t1_vedar estado=%0d alarme=%b exp=3,0", estado, alarme_rolha); end
    key_vedar = 1; tick(); key_vedar = 0;
    n_cmp++; if (estado !== 4'd4 || atuador_vedacao !== 1'b1 || rolhas !== 5'd4 || dispensador !== 1'b1) begin
      n_err++; $display("FAIL t1_selando estado=%0d atuador=%b rolhas=%0d disp=%b exp=4,1,4,1", estado, atuador_vedacao, rolhas, dispensador); end
    repeat (3) tick();
    n_cmp++; if (estado !== 4'd4) begin n_err++; $display("FAIL t1_selando_hold estado=%0d exp=4", estado); end
    tick();
    n_cmp++; if (estado !== 4'd5 || motor !== 1'b1) begin n_err++; $display("FAIL t1_move_cq estado=%0d motor=%b exp=5,1", estado, motor); end
    sens_pos_cq = 1; tick(); sens_pos_cq = 0;
    n_cmp++; if (estado !== 4'd6) begin n_err++; $display("FAIL t1_cq estado=%0d exp=6", estado); end
    qualidade_ok = 1; key_enter_cq = 1; tick(); key_enter_cq = 0;
    n_cmp++; if (estado !== 4'd8 || motor !== 1'b1) begin n_err++; $display("FAIL t1_move_lacre estado=%0d exp=8", estado); end
    sens_pos_lacre = 1; tick(); sens_pos_lacre = 0;
    n_cmp++; if (estado !== 4'd9) begin n_err++; $display("FAIL t1_lacre estado=%0d exp=9", estado); end
    key_lacre = 1; tick(); key_lacre = 0;
    n_cmp++; if (estado !== 4'd0 || garrafas !== 4'd1 || rolhas !== 5'd4) begin
      n_err++; $display("FAIL t1_done estado=%0d garrafas=%0d rolhas=%0d exp=0,1,4", estado, garrafas, rolhas); end
  endtask

  task automatic test_empty_stock_and_discard();
    int cnt;
    reset = 1; tick(); reset = 0;
    start = 1; tick(); start = 0;
    sens_pos_ench = 1; tick(); sens_pos_ench = 0;
    sens_cheia = 1; tick(); sens_cheia = 0;
    n_cmp++; if (estado !== 4'd3 || alarme_rolha !== 1'b1) begin n_err++; $display("FAIL t2_alarm estado=%0d alarme=%b exp=3,1", estado, alarme_rolha); end
    key_vedar = 1; tick(); key_vedar = 0;
    n_cmp++; if (estado !== 4'd3 || alarme_rolha !== 1'b1 || rolhas !== 5'd0) begin
      n_err++; $display("FAIL t2_seal_ignored estado=%0d alarme=%b rolhas=%0d exp=3,1,0", estado, alarme_rolha, rolhas); end
    add_rolha = 1; tick(); add_rolha = 0;
    n_cmp++; if (estado !== 4'd3 || alarme_rolha !== 1'b0 || rolhas !== 5'd5) begin
      n_err++; $display("FAIL t2_refill estado=%0d alarme=%b rolhas=%0d exp=3,0,5", estado, alarme_rolha, rolhas); end
    key_vedar = 1; tick(); key_vedar = 0;
    cnt = 0;
    for (int i = 0; i < 20 && atuador_vedacao; i++) begin cnt++; tick(); end
    n_cmp++; if (cnt !== 4 || estado !== 4'd5) begin n_err++; $display("FAIL t2_sela_len cycles=%0d estado=%0d exp=4,5", cnt, estado); end
    sens_pos_cq = 1; tick(); sens_pos_cq = 0;
    qualidade_ok = 0; key_enter_cq = 1; tick(); key_enter_cq = 0;
    n_cmp++; if (estado !== 4'd7) begin n_err++; $display("FAIL t3_descarte estado=%0d exp=7", estado); end
    cnt = 0;
    for (int i = 0; i < 20 && led_descarte; i++) begin cnt++; tick(); end
    n_cmp++; if (cnt !== 8) begin n_err++; $display("FAIL t3_desc_len cycles=%0d exp=8", cnt); end
    n_cmp++; if (estado !== 4'd0 || garrafas !== 4'd0 || rolhas !== 5'd4) begin
      n_err++; $display("FAIL t3_after estado=%0d garrafas=%0d rolhas=%0d exp=0,0,4", estado, garrafas, rolhas); end
  endtask

  task automatic test_box_count();
    repeat (11) drive_bottle(1'b1);
    n_cmp++; if (garrafas !== 4'd11 || caixas !== 4'd0) begin n_err++; $display("FAIL t4_eleven garrafas=%0d caixas=%0d exp=11,0", garrafas, caixas); end
    drive_bottle(1'b1);
    n_cmp++; if (garrafas !== 4'd0 || caixas !== 4'd1 || caixas_cheio !== 1'b0) begin
      n_err++; $display("FAIL t4_box garrafas=%0d caixas=%0d cheio=%b exp=0,1,0", garrafas, caixas, caixas_cheio); end
    repeat (96) drive_bottle(1'b1);
    n_cmp++; if (caixas !== 4'd9 || caixas_cheio !== 1'b0) begin n_err++; $display("FAIL t4_nine caixas=%0d cheio=%b exp=9,0", caixas, caixas_cheio); end
    repeat (12) drive_bottle(1'b1);
    n_cmp++; if (caixas !== 4'd10 || caixas_cheio !== 1'b1) begin n_err++; $display("FAIL t4_ten caixas=%0d cheio=%b exp=10,1", caixas, caixas_cheio); end
    repeat (12) drive_bottle(1'b1);
    n_cmp++; if (caixas !== 4'd10 || caixas_cheio !== 1'b1 || garrafas !== 4'd0) begin
      n_err++; $display("FAIL t4_saturate caixas=%0d cheio=%b garrafas=%0d exp=10,1,0", caixas, caixas_cheio, garrafas); end
    n_cmp++; if (rolhas !== 5'd19) begin n_err++; $display("FAIL t4_rolhas got=%0d exp=19", rolhas); end
  endtask

  task automatic test_timeout();
    int cnt;
    start = 1; tick(); start = 0;
    cnt = 0;
    for (int i = 0; i < 300 && estado == 4'd1; i++) begin cnt++; tick(); end
    n_cmp++; if (cnt !== 255) begin n_err++; $display("FAIL t5_timeout_len cycles=%0d exp=255", cnt); end
    n_cmp++; if (estado !== 4'd15 || fault !== 1'b1 || motor !== 1'b0 || valvula !== 1'b0) begin
      n_err++; $display("FAIL t5_fault estado=%0d fault=%b motor=%b exp=15,1,0", estado, fault, motor); end
    start = 1; tick(); start = 0;
    n_cmp++; if (estado !== 4'd15) begin n_err++; $display("FAIL t5_start_ignored estado=%0d exp=15", estado); end
    add_rolha = 1; tick(); add_rolha = 0;
    n_cmp++; if (rolhas !== 5'd20) begin n_err++; $display("FAIL t5_add_in_fault rolhas=%0d exp=20", rolhas); end
    clear_fault = 1; tick(); clear_fault = 0;
    n_cmp++; if (estado !== 4'd0 || fault !== 1'b0 || caixas !== 4'd10) begin
      n_err++; $display("FAIL t5_clear estado=%0d fault=%b caixas=%0d exp=0,0,10", estado, fault, caixas); end
  endtask

  task automatic test_saturate_and_reset();
    reset = 1; tick(); reset = 0;
    repeat (4) begin add_rolha = 1; tick(); add_rolha = 0; end
    n_cmp++; if (rolhas !== 5'd20) begin n_err++; $display("FAIL t6_fill rolhas=%0d exp=20", rolhas); end
    start = 1; tick(); start = 0;
    sens_pos_ench = 1; tick(); sens_pos_ench = 0;
    sens_cheia = 1; tick(); sens_cheia = 0;
    key_vedar = 1; tick(); key_vedar = 0;
    repeat (4) tick();
    sens_pos_cq = 1; tick(); sens_pos_cq = 0;
    qualidade_ok = 0; key_enter_cq = 1; tick(); key_enter_cq = 0;
    repeat (8) tick();
    n_cmp++; if (rolhas !== 5'd19 || estado !== 4'd0) begin n_err++; $display("FAIL t6_nineteen rolhas=%0d estado=%0d exp=19,0", rolhas, estado); end
    start = 1; tick(); start = 0;
    sens_pos_ench = 1; tick(); sens_pos_ench = 0;
    sens_cheia = 1; tick(); sens_cheia = 0;
    key_vedar = 1; add_rolha = 1; tick(); key_vedar = 0; add_rolha = 0;
    n_cmp++; if (rolhas !== 5'd20 || estado !== 4'd4) begin n_err++; $display("FAIL t6_sat rolhas=%0d estado=%0d exp=20,4", rolhas, estado); end
    reset = 1; start = 1; tick(); reset = 0; start = 0;
    n_cmp++; if (estado !== 4'd0 || atuador_vedacao !== 1'b0 || motor !== 1'b0 || fault !== 1'b0) begin
      n_err++; $display("FAIL t6_reset_state estado=%0d atuador=%b motor=%b exp=0,0,0", estado, atuador_vedacao, motor); end
    n_cmp++; if (rolhas !== 5'd0 || dispensador !== 1'b1 || garrafas !== 4'd0 || caixas !== 4'd0) begin
      n_err++; $display("FAIL t6_reset_counters rolhas=%0d disp=%b garrafas=%0d caixas=%0d exp=0,1,0,0", rolhas, dispensador, garrafas, caixas); end
  endtask

  initial begin
    test_reset();
    test_full_cycle();
    test_empty_stock_and_discard();
    test_box_count();
    test_timeout();
    test_saturate_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
